// File: rtl/conv_layer_ctrl.sv
// conv_layer_ctrl: sequences one convolution layer.
// For each input channel it loads the image and then each filter. It drives
// the convolution engine for each map and writes every result to memory.
// When accumulate=1 it first reads back the partial sum and adds it with
// saturation. ReLU is applied on the final channel.
module conv_layer_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  imgsNumber,
    input  logic [CNT_W-1:0]  imgSize,
    input  logic [ADDR_W-1:0] imgsAddress,
    input  logic [CNT_W-1:0]  filtersNumber,
    input  logic [CNT_W-1:0]  filterSize,
    input  logic [ADDR_W-1:0] filterAddress,
    input  logic [ADDR_W-1:0] outAddress,
    input  logic              accumulate,
    input  logic              relu,
    output logic              loadEnable,
    output logic [ADDR_W-1:0] loadAddr,
    output logic [CNT_W-1:0]  loadSize,
    output logic              loadType,
    input  logic              loadDone,
    output logic              convEnable,
    input  logic              convValid,
    input  logic [DATA_W-1:0] convOut,
    output logic              convReady,
    input  logic              convDone,
    output logic              prevEnable,
    output logic [ADDR_W-1:0] prevAddr,
    input  logic              prevDone,
    input  logic [DATA_W-1:0] prevData,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeOut,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, LOAD_IMG, LOAD_FLT, CONV, RD_PREV, WRITE, NEXT, FIN
    } state_t;

    state_t state, state_nx;

    logic [1:0]        rst_sync;
    logic              rst_n_i;
    logic [CNT_W-1:0]  cfg_i, cfg_p, cfg_n, cfg_k, i_cnt, o_cnt;
    logic [ADDR_W-1:0] cfg_nn, cfg_kk, cfg_s, cfg_out;
    logic              cfg_acc, cfg_relu;
    logic [ADDR_W-1:0] img_addr, flt_addr, out_base, pix;
    logic [DATA_W-1:0] val_q, sat_sum;
    logic [DATA_W:0]   sum_w;
    logic              pend_done;
    logic [CNT_W-1:0]  div_i, p_calc, r_calc, m_calc;
    logic [ADDR_W-1:0] n_a, k_a, m_a;
    logic              cfg_bad, o_last, i_last, relu_on;

    // Reset asserts asynchronously and is released in step with clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    // Configuration checks and derived sizes, evaluated at start.
    always_comb begin
        div_i   = (imgsNumber == '0) ? CNT_W'(1) : imgsNumber;
        p_calc  = filtersNumber / div_i;
        r_calc  = filtersNumber % div_i;
        cfg_bad = (imgsNumber == '0) || (filtersNumber == '0) || (r_calc != '0) ||
                  (filterSize == '0) || (filterSize > imgSize);
        m_calc  = imgSize - filterSize + CNT_W'(1);
        n_a     = ADDR_W'(imgSize);
        k_a     = ADDR_W'(filterSize);
        m_a     = ADDR_W'(m_calc);
    end

    assign o_last  = (o_cnt == cfg_p - CNT_W'(1));
    assign i_last  = (i_cnt == cfg_i - CNT_W'(1));
    assign relu_on = cfg_relu && (!cfg_acc || i_last);

    // Saturating add of the engine result and the partial sum.
    assign sum_w = {val_q[DATA_W-1], val_q} + {prevData[DATA_W-1], prevData};
    always_comb begin
        if (sum_w[DATA_W] != sum_w[DATA_W-1])
            sat_sum = sum_w[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat_sum = sum_w[DATA_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nx;
    end

    // Datapath: configuration, loop counters, running addresses, result.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cfg_i <= '0; cfg_p <= '0; cfg_n <= '0; cfg_k <= '0;
            cfg_nn <= '0; cfg_kk <= '0; cfg_s <= '0; cfg_out <= '0;
            cfg_acc <= 1'b0; cfg_relu <= 1'b0;
            i_cnt <= '0; o_cnt <= '0; pix <= '0;
            img_addr <= '0; flt_addr <= '0; out_base <= '0;
            val_q <= '0; pend_done <= 1'b0; done <= 1'b0; err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (cfg_bad) begin
                        done <= 1'b1;
                        err  <= 1'b1;
                    end else begin
                        done <= 1'b0;
                        err  <= 1'b0;
                        cfg_i <= imgsNumber; cfg_p <= p_calc;
                        cfg_n <= imgSize;    cfg_k <= filterSize;
                        cfg_nn <= n_a * n_a; cfg_kk <= k_a * k_a;
                        cfg_s <= m_a * m_a;  cfg_out <= outAddress;
                        cfg_acc <= accumulate; cfg_relu <= relu;
                        i_cnt <= '0; o_cnt <= '0; pix <= '0;
                        img_addr <= imgsAddress; flt_addr <= filterAddress;
                        out_base <= outAddress; pend_done <= 1'b0;
                    end
                end
                CONV: if (convValid) begin
                    val_q <= convOut;
                    // A convDone arriving with the last result is remembered
                    // so the map closes after that result is written.
                    if (convDone) pend_done <= 1'b1;
                end
                RD_PREV: if (prevDone) val_q <= sat_sum;
                WRITE: pix <= pix + ADDR_W'(1);
                NEXT: begin
                    pix <= '0;
                    pend_done <= 1'b0;
                    flt_addr <= flt_addr + cfg_kk;
                    if (o_last) begin
                        o_cnt <= '0;
                        i_cnt <= i_cnt + CNT_W'(1);
                        img_addr <= img_addr + cfg_nn;
                        out_base <= cfg_acc ? cfg_out : out_base + cfg_s;
                        if (i_last) done <= 1'b1;
                    end else begin
                        o_cnt <= o_cnt + CNT_W'(1);
                        out_base <= out_base + cfg_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx    = state;
        loadEnable  = 1'b0;
        loadAddr    = '0;
        loadSize    = '0;
        loadType    = 1'b0;
        convEnable  = 1'b0;
        convReady   = 1'b0;
        prevEnable  = 1'b0;
        prevAddr    = '0;
        writeEnable = 1'b0;
        writeAddr   = '0;
        writeOut    = '0;
        busy        = (state != IDLE) && (state != FIN);
        case (state)
            IDLE: if (start && !cfg_bad) state_nx = LOAD_IMG;
            LOAD_IMG: begin
                loadEnable = 1'b1;
                loadAddr   = img_addr;
                loadSize   = cfg_n;
                if (loadDone) state_nx = LOAD_FLT;
            end
            LOAD_FLT: begin
                loadEnable = 1'b1;
                loadAddr   = flt_addr;
                loadSize   = cfg_k;
                loadType   = 1'b1;
                if (loadDone) state_nx = CONV;
            end
            CONV: begin
                convEnable = 1'b1;
                convReady  = 1'b1;
                if (convValid)
                    state_nx = (cfg_acc && (i_cnt != '0)) ? RD_PREV : WRITE;
                else if (convDone)
                    state_nx = NEXT;
            end
            RD_PREV: begin
                convEnable = 1'b1;
                prevEnable = 1'b1;
                prevAddr   = out_base + pix;
                if (prevDone) state_nx = WRITE;
            end
            WRITE: begin
                convEnable  = 1'b1;
                writeEnable = 1'b1;
                writeAddr   = out_base + pix;
                writeOut    = (relu_on && val_q[DATA_W-1]) ? '0 : val_q;
                state_nx    = pend_done ? NEXT : CONV;
            end
            NEXT: state_nx = o_last ? (i_last ? FIN : LOAD_IMG) : LOAD_FLT;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench for conv_layer_ctrl. Models the load, conv-engine and
// partial-sum blocks, and compares writes, loads and read-backs against queues.
module tb_conv_layer_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int CW = 16;

    logic clk, reset, start, accumulate, relu;
    logic [CW-1:0] imgsNumber, imgSize, filtersNumber, filterSize, loadSize;
    logic [AW-1:0] imgsAddress, filterAddress, outAddress, loadAddr, prevAddr, writeAddr;
    logic loadEnable, loadType, loadDone, convEnable, convValid, convReady, convDone;
    logic prevEnable, prevDone, writeEnable, busy, done, err;
    logic [DW-1:0] convOut, prevData, writeOut;

    conv_layer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imgsNumber(imgsNumber), .imgSize(imgSize), .imgsAddress(imgsAddress),
        .filtersNumber(filtersNumber), .filterSize(filterSize),
        .filterAddress(filterAddress), .outAddress(outAddress),
        .accumulate(accumulate), .relu(relu),
        .loadEnable(loadEnable), .loadAddr(loadAddr), .loadSize(loadSize),
        .loadType(loadType), .loadDone(loadDone),
        .convEnable(convEnable), .convValid(convValid), .convOut(convOut),
        .convReady(convReady), .convDone(convDone),
        .prevEnable(prevEnable), .prevAddr(prevAddr), .prevDone(prevDone),
        .prevData(prevData),
        .writeEnable(writeEnable), .writeAddr(writeAddr), .writeOut(writeOut),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [AW-1:0] addr; logic [CW-1:0] size; logic typ; } ld_t;

    wr_t exp_wr[$];
    ld_t exp_ld[$];
    logic [AW-1:0] exp_prev[$];
    logic [DW-1:0] conv_q[$];
    wr_t e_wr;
    ld_t e_ld;
    logic [AW-1:0] e_prev;

    int checks = 0;
    int errors = 0;
    int map_len = 0;
    logic [DW-1:0] prev_val = '0;
    int img_loads = 0;
    int lcnt = 0, pcnt = 0, ecnt = 0;
    logic hs_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(posedge clk) hs_last <= convValid && convReady;

    // Environment models: load block, partial-sum memory and conv engine.
    initial begin
        loadDone = 0; convValid = 0; convDone = 0; prevDone = 0;
        convOut = '0; prevData = '0;
        forever begin
            @(negedge clk);
            loadDone = 0; convDone = 0; prevDone = 0;
            if (!reset) begin
                convValid = 0; lcnt = 0; pcnt = 0; ecnt = 0;
                continue;
            end
            if (loadEnable) begin
                lcnt++;
                if (lcnt == 2) begin loadDone = 1; lcnt = 0; end
            end else lcnt = 0;
            if (prevEnable) begin
                pcnt++;
                if (pcnt == 2) begin prevDone = 1; prevData = prev_val; pcnt = 0; end
            end else pcnt = 0;
            if (!convEnable) begin
                convValid = 0; ecnt = 0;
            end else begin
                if (convValid && hs_last) begin convValid = 0; ecnt++; end
                if (!convValid) begin
                    if (ecnt < map_len) begin
                        if (conv_q.size() > 0) begin convValid = 1; convOut = conv_q.pop_front(); end
                    end else if (convReady) convDone = 1;
                end
            end
        end
    end

    // Monitor: pops expected transactions whenever the DUT presents one.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (writeEnable) begin
                    if (exp_wr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none", writeAddr, writeOut);
                    end else begin
                        e_wr = exp_wr.pop_front();
                        check("write_addr", 32'(writeAddr), 32'(e_wr.addr));
                        check("write_data", 32'(writeOut), 32'(e_wr.data));
                    end
                end
                if (loadEnable && loadDone) begin
                    if (!loadType) img_loads++;
                    if (exp_ld.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_load: got addr %0h expected none", loadAddr);
                    end else begin
                        e_ld = exp_ld.pop_front();
                        check("load_addr", 32'(loadAddr), 32'(e_ld.addr));
                        check("load_size", 32'(loadSize), 32'(e_ld.size));
                        check("load_type", 32'(loadType), 32'(e_ld.typ));
                    end
                end
                if (prevEnable && prevDone) begin
                    if (exp_prev.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_prev: got addr %0h expected none", prevAddr);
                    end else begin
                        e_prev = exp_prev.pop_front();
                        check("prev_addr", 32'(prevAddr), 32'(e_prev));
                    end
                end
            end
        end
    end

    task automatic start_cfg(input int ni, input int nn, input int nk, input int nf,
                             input logic [AW-1:0] ia, input logic [AW-1:0] fa,
                             input logic [AW-1:0] oa, input logic acc, input logic rl);
        @(negedge clk);
        imgsNumber = CW'(ni); imgSize = CW'(nn); filterSize = CW'(nk);
        filtersNumber = CW'(nf); imgsAddress = ia; filterAddress = fa;
        outAddress = oa; accumulate = acc; relu = rl;
        map_len = (nn - nk + 1) * (nn - nk + 1);
        start = 1;
        @(negedge clk);
        start = 0;
        imgsNumber = '0; imgSize = '0; filtersNumber = '0; filterSize = '0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!done && t < 20000) begin @(negedge clk); t++; end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_err_low"}, 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
        check({name, "_loads_left"}, 32'(exp_ld.size()), 32'd0);
        check({name, "_prev_left"}, 32'(exp_prev.size()), 32'd0);
    endtask

    task automatic push_t1();
        conv_q.push_back(16'd5); conv_q.push_back(16'hFFFD);
        conv_q.push_back(16'd7); conv_q.push_back(16'd9);
        exp_ld.push_back('{addr: 16'h0000, size: 16'd4, typ: 1'b0});
        exp_ld.push_back('{addr: 16'h0200, size: 16'd3, typ: 1'b1});
        exp_wr.push_back('{addr: 16'h0100, data: 16'd5});
        exp_wr.push_back('{addr: 16'h0101, data: 16'd0});
        exp_wr.push_back('{addr: 16'h0102, data: 16'd7});
        exp_wr.push_back('{addr: 16'h0103, data: 16'd9});
    endtask

    task automatic push_t2();
        conv_q.push_back(16'd3); conv_q.push_back(16'hFFFC);
        conv_q.push_back(16'hFFEC); conv_q.push_back(16'hFFEC);
        exp_ld.push_back('{addr: 16'h0040, size: 16'd3, typ: 1'b0});
        exp_ld.push_back('{addr: 16'h0080, size: 16'd3, typ: 1'b1});
        exp_ld.push_back('{addr: 16'h0089, size: 16'd3, typ: 1'b1});
        exp_ld.push_back('{addr: 16'h0049, size: 16'd3, typ: 1'b0});
        exp_ld.push_back('{addr: 16'h0092, size: 16'd3, typ: 1'b1});
        exp_ld.push_back('{addr: 16'h009B, size: 16'd3, typ: 1'b1});
        exp_wr.push_back('{addr: 16'h0300, data: 16'd3});
        exp_wr.push_back('{addr: 16'h0301, data: 16'hFFFC});
        exp_wr.push_back('{addr: 16'h0300, data: 16'd0});
        exp_wr.push_back('{addr: 16'h0301, data: 16'd0});
        exp_prev.push_back(16'h0300); exp_prev.push_back(16'h0301);
        prev_val = 16'd10;
    endtask

    task automatic push_t3(input logic [DW-1:0] c1, input logic [DW-1:0] pv, input logic [DW-1:0] res);
        conv_q.push_back(16'd5); conv_q.push_back(c1);
        exp_ld.push_back('{addr: 16'h0000, size: 16'd1, typ: 1'b0});
        exp_ld.push_back('{addr: 16'h0010, size: 16'd1, typ: 1'b1});
        exp_ld.push_back('{addr: 16'h0001, size: 16'd1, typ: 1'b0});
        exp_ld.push_back('{addr: 16'h0011, size: 16'd1, typ: 1'b1});
        exp_wr.push_back('{addr: 16'h0500, data: 16'd5});
        exp_wr.push_back('{addr: 16'h0500, data: res});
        exp_prev.push_back(16'h0500);
        prev_val = pv;
    endtask

    initial begin
        int t, ld_cycles;
        reset = 0; start = 0; accumulate = 0; relu = 0;
        imgsNumber = '0; imgSize = '0; filtersNumber = '0; filterSize = '0;
        imgsAddress = '0; filterAddress = '0; outAddress = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_load", 32'({loadEnable, loadAddr}), 32'd0);
        check("rst_write", 32'({writeEnable, writeAddr}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (5) @(negedge clk);

        // T1: single channel, ReLU clamps the negative pixel.
        push_t1();
        start_cfg(1, 4, 3, 1, 16'h0000, 16'h0200, 16'h0100, 1'b0, 1'b1);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_load_after_start", 32'(loadEnable), 32'd1);
        check("t1_done_cleared", 32'(done), 32'd0);
        wait_done("t1");

        // T2: accumulation over two channels, 1x1 output maps.
        push_t2();
        start_cfg(2, 3, 3, 4, 16'h0040, 16'h0080, 16'h0300, 1'b1, 1'b1);
        wait_done("t2");

        // T3: positive and negative saturation on read-back.
        push_t3(16'd32000, 16'd1000, 16'h7FFF);
        start_cfg(2, 1, 1, 2, 16'h0000, 16'h0010, 16'h0500, 1'b1, 1'b0);
        wait_done("t3a");
        push_t3(16'h8300, 16'hFC18, 16'h8000);
        start_cfg(2, 1, 1, 2, 16'h0000, 16'h0010, 16'h0500, 1'b1, 1'b0);
        wait_done("t3b");

        // T4: filter count not divisible by channel count.
        start_cfg(2, 4, 2, 3, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check("t4_err", 32'(err), 32'd1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        ld_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            if (loadEnable) ld_cycles++;
            @(negedge clk);
        end
        check("t4_no_loads", 32'(ld_cycles), 32'd0);

        // T5: load order and output placement, no accumulation.
        img_loads = 0;
        for (int ch = 0; ch < 2; ch++) begin
            exp_ld.push_back('{addr: AW'(16'h1000 + ch * 16), size: 16'd4, typ: 1'b0});
            for (int o = 0; o < 2; o++)
                exp_ld.push_back('{addr: AW'(16'h2000 + (ch * 2 + o) * 4), size: 16'd2, typ: 1'b1});
        end
        for (int f = 0; f < 4; f++)
            for (int p = 0; p < 9; p++) begin
                conv_q.push_back(DW'(f * 16 + p));
                exp_wr.push_back('{addr: AW'(16'h3000 + f * 9 + p), data: DW'(f * 16 + p)});
            end
        start_cfg(2, 4, 2, 4, 16'h1000, 16'h2000, 16'h3000, 1'b0, 1'b0);
        check("t5_err_cleared", 32'(err), 32'd0);
        wait_done("t5");
        check("t5_img_loads", 32'(img_loads), 32'd2);

        // T6: reset while a partial-sum read is pending, then a clean run.
        push_t2();
        start_cfg(2, 3, 3, 4, 16'h0040, 16'h0080, 16'h0300, 1'b1, 1'b1);
        t = 0;
        while (!prevEnable && t < 2000) begin @(negedge clk); t++; end
        check("t6_prev_seen", 32'(prevEnable), 32'd1);
        #2;
        reset = 0;
        #1;
        check("t6_rst_prev", 32'({prevEnable, prevAddr}), 32'd0);
        check("t6_rst_conv", 32'({convEnable, convReady, loadEnable, loadType, writeEnable}), 32'd0);
        check("t6_rst_flags", 32'({busy, done, err}), 32'd0);
        check("t6_rst_data", 32'({writeOut, loadSize}), 32'd0);
        exp_wr.delete(); exp_ld.delete(); exp_prev.delete(); conv_q.delete();
        repeat (3) @(negedge clk);
        reset = 1;
        repeat (5) @(negedge clk);
        push_t1();
        start_cfg(1, 4, 3, 1, 16'h0000, 16'h0200, 16'h0100, 1'b0, 1'b1);
        wait_done("t6_rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_ctrl.md
# conv_layer_ctrl

Parametrised sequencer for one convolution layer: fetches each input channel and its filters through the shared load block, drives an external convolution engine, and writes each result to memory. Optional accumulation across input channels through a partial-sum read-back, with saturation and ReLU on the final channel. Sits between the layer scheduler and the load/write/conv-engine blocks, replacing the fixed-width controller.

## Interface
- DATA_W, 16, data word width (signed)
- ADDR_W, 16, memory address width
- CNT_W, 16, width of size/count configuration inputs

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- imgsNumber  in  CNT_W  input channels (I)
- imgSize  in  CNT_W  input map side (N)
- imgsAddress  in  ADDR_W  base of channel 0
- filtersNumber  in  CNT_W  total filters (F)
- filterSize  in  CNT_W  filter side (K)
- filterAddress  in  ADDR_W  base of filter 0
- outAddress  in  ADDR_W  base of output maps
- accumulate  in  1  1: sum over channels; 0: one map per filter
- relu  in  1  clamp negative writes to 0
- loadEnable  out  1  load request, held until loadDone
- loadAddr  out  ADDR_W  load base address
- loadSize  out  CNT_W  side of square block to load
- loadType  out  1  0 image, 1 filter
- loadDone  in  1  one-cycle completion pulse
- convEnable  out  1  held high while engine runs on current image/filter
- convValid  in  1  engine result valid
- convOut  in  DATA_W  engine result, raster order
- convReady  out  1  controller accepts convOut this cycle
- convDone  in  1  engine finished current map
- prevEnable  out  1  partial-sum read request, held until prevDone
- prevAddr  out  ADDR_W  partial-sum address
- prevDone  in  1  one-cycle pulse, prevData valid
- prevData  in  DATA_W  partial sum
- writeEnable  out  1  one-cycle write strobe
- writeAddr  out  ADDR_W  write address
- writeOut  out  DATA_W  write data
- busy  out  1  high from accepted start until done
- done  out  1  high from completion until next accepted start
- err  out  1  configuration error flag, same lifetime as done

## Operation
- P = F / I filters per channel, M = N-K+1, S = M*M. Config registered on accepted start; inputs ignored thereafter.
- Error: I==0, F==0, F mod I != 0, K==0 or K>N -> err=1, done=1, no requests issued.
- Filter index f = i*P + o (channel i, output o). Image base imgsAddress + i*N*N; filter base filterAddress + f*K*K.
- Output map base: accumulate=1 -> outAddress + o*S; accumulate=0 -> outAddress + f*S. Pixel p at base + p.
- States: IDLE -> LOAD_IMG -> LOAD_FLT -> CONV -> (RD_PREV) -> WRITE -> CONV ... -> NEXT -> LOAD_FLT or LOAD_IMG or FIN -> IDLE.
- LOAD_IMG/LOAD_FLT: loadEnable=1 with addr/size/type stable until loadDone; image reloaded only when i advances.
- CONV: convEnable=1, convReady=1. On convValid&convReady capture convOut, drop convReady; go RD_PREV if accumulate=1 and i>0, else WRITE.
- RD_PREV: prevEnable=1, prevAddr=pixel address until prevDone; sum = sat(convOut + prevData).
- WRITE: one writeEnable strobe; value = sum (or convOut); ReLU applied if relu=1 and (accumulate=0 or i==I-1). Return to CONV.
- convDone with no pending result -> NEXT: o+1; at o==P: o=0, i+1; at i==I -> FIN.
- Saturation: DATA_W+1-bit signed sum clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Address arithmetic modulo 2^ADDR_W (wraps silently).

## Timing
- Reset (async assert, sync deassert internally): state IDLE, every output 0, counters 0.
- start -> loadEnable high next cycle; busy high same edge.
- loadDone -> next request issued next cycle. Pixel throughput: 2 cycles/result without read-back, 3 + prevDone latency with.
- Simultaneous convValid and convDone: result processed first, then NEXT.
- start while busy ignored. reset mid-operation aborts immediately; no further strobes.
- FIN: busy=0, done=1 one cycle after last write strobe.

## Test plan
- I=1, N=4, K=3, F=1, accumulate=0, outAddress=0x100, conv results 5,-3,7,9, relu=1 -> writes (0x100,5),(0x101,0),(0x102,7),(0x103,9), done.
- I=2, F=4, N=3, K=3 (S=1), accumulate=1, prevData=10, convOut=-20 on channel 1, relu=1 -> channel-0 writes without prevEnable; channel-1 writes 0 at outAddress+o.
- DATA_W=16, accumulate, convOut=32000, prevData=1000 -> writeOut=32767; -32000 + -1000 -> -32768.
- F=3, I=2 -> err=1, done=1 next cycle, zero loadEnable pulses.
- Load order check I=2, F=4, N=4, K=2: image addresses base, base+16; filter addresses base+0,4,8,12; exactly 2 image loads.
- Reset low while prevEnable pending -> all outputs 0 asynchronously; new start afterwards completes normally.
